ebi_bus_controller: RTL and testbench

- Sequences host EBI transactions into single-cycle register-file accesses for the mecobo pin/PWM datapath.
- Synchronises the asynchronous EBI strobes (ebi_cs, ebi_wr, ebi_rd) and detects their rising edges.
- Latches address and write data, then issues write/read handshakes to the backend register bus.
- Returns read data on the EBI data bus, with a timeout guard and an internal status register.

---
 rtl/ebi_bus_controller.sv | 188 ++++++++++++++++++
 tb/tb_ebi_bus_controller.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebi_bus_controller.sv
// rtl/ebi_bus_controller.sv - EBI host strobe sequencer driving a single-cycle register bus
//
// Ports:
//   clk, reset            system clock, asynchronous active-low reset
//   ebi_cs/wr/rd          asynchronous host strobes (synchronised internally)
//   ebi_addr, ebi_data_in host address / write data, stable around the strobes
//   ebi_data_out, _oe     read data returned to the host and its pad enable
//   reg_addr, reg_wdata   backend address / write data
//   reg_we, reg_re        one-cycle backend write / read request pulses
//   reg_rdata, reg_rvalid backend read response
//   busy                  high whenever a transaction is in progress
module ebi_bus_controller #(
    parameter int                    ADDR_WIDTH  = 21,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    TIMEOUT     = 15,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 21'h1FFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ebi_cs,
    input  logic                  ebi_wr,
    input  logic                  ebi_rd,
    input  logic [ADDR_WIDTH-1:0] ebi_addr,
    input  logic [DATA_WIDTH-1:0] ebi_data_in,
    output logic [DATA_WIDTH-1:0] ebi_data_out,
    output logic                  ebi_data_oe,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_rvalid,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_REQ,
        RD_WAIT,
        RD_HOLD,
        DONE
    } state_t;

    localparam logic [7:0]            TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] DEAD_WORD   = DATA_WIDTH'(16'hDEAD);

    // Two-flop synchronisers plus a "previous" flop on the qualified levels
    logic cs_meta, cs_s;
    logic wr_meta, wr_s;
    logic rd_meta, rd_s;
    logic wr_prev, rd_prev;
    logic wr_lvl, rd_lvl;
    logic wr_go, rd_go;

    assign wr_lvl = cs_s & wr_s;
    assign rd_lvl = cs_s & rd_s;
    assign wr_go  = wr_lvl & ~wr_prev;
    assign rd_go  = rd_lvl & ~rd_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_meta <= 1'b0;
            cs_s    <= 1'b0;
            wr_meta <= 1'b0;
            wr_s    <= 1'b0;
            rd_meta <= 1'b0;
            rd_s    <= 1'b0;
            wr_prev <= 1'b0;
            rd_prev <= 1'b0;
        end else begin
            cs_meta <= ebi_cs;
            cs_s    <= cs_meta;
            wr_meta <= ebi_wr;
            wr_s    <= wr_meta;
            rd_meta <= ebi_rd;
            rd_s    <= rd_meta;
            wr_prev <= wr_lvl;
            rd_prev <= rd_lvl;
        end
    end

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [DATA_WIDTH-1:0]   dout_d;
    logic                    we_d, re_d;
    logic [7:0]              wait_cnt, wait_d;
    logic [7:0]              timeout_cnt, tcnt_d;
    logic [DATA_WIDTH-1:0]   status_word;

    assign status_word = {{(DATA_WIDTH-8){1'b0}}, timeout_cnt};

    always_comb begin
        state_d = state;
        addr_d  = reg_addr;
        wdata_d = reg_wdata;
        dout_d  = ebi_data_out;
        we_d    = 1'b0;
        re_d    = 1'b0;
        wait_d  = wait_cnt;
        tcnt_d  = timeout_cnt;
        case (state)
            IDLE: begin
                // A simultaneous write and read edge performs the write only
                if (wr_go) begin
                    addr_d  = ebi_addr;
                    wdata_d = ebi_data_in;
                    if (ebi_addr == STATUS_ADDR) begin
                        tcnt_d  = 8'h00;
                        state_d = DONE;
                    end else begin
                        state_d = WRITE;
                    end
                end else if (rd_go) begin
                    addr_d = ebi_addr;
                    if (ebi_addr == STATUS_ADDR) begin
                        dout_d  = status_word;
                        state_d = RD_HOLD;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            WRITE: begin
                we_d    = 1'b1;
                state_d = DONE;
            end
            RD_REQ: begin
                re_d    = 1'b1;
                wait_d  = 8'h00;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                wait_d = wait_cnt + 8'h01;
                // Response data takes priority over a timeout in the same cycle
                if (reg_rvalid) begin
                    dout_d  = reg_rdata;
                    state_d = RD_HOLD;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    dout_d = DEAD_WORD;
                    if (timeout_cnt != 8'hFF) begin
                        tcnt_d = timeout_cnt + 8'h01;
                    end
                    state_d = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (!rd_lvl) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                // Hold here until the host lets go so a held strobe cannot retrigger
                if (!cs_s && !wr_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            reg_we       <= 1'b0;
            reg_re       <= 1'b0;
            ebi_data_out <= '0;
            wait_cnt     <= 8'h00;
            timeout_cnt  <= 8'h00;
        end else begin
            state        <= state_d;
            reg_addr     <= addr_d;
            reg_wdata    <= wdata_d;
            reg_we       <= we_d;
            reg_re       <= re_d;
            ebi_data_out <= dout_d;
            wait_cnt     <= wait_d;
            timeout_cnt  <= tcnt_d;
        end
    end

    assign ebi_data_oe = (state == RD_HOLD) & rd_lvl;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ebi_bus_controller.sv
// tb/tb_ebi_bus_controller.sv - scoreboard bench for ebi_bus_controller
module tb_ebi_bus_controller;

    localparam int                AW     = 21;
    localparam int                DW     = 16;
    localparam logic [AW-1:0]     STATUS = 21'h1FFFFF;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ebi_cs = 1'b0, ebi_wr = 1'b0, ebi_rd = 1'b0;
    logic [AW-1:0] ebi_addr = '0;
    logic [DW-1:0] ebi_data_in = '0;
    logic [DW-1:0] ebi_data_out;
    logic          ebi_data_oe;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_we, reg_re;
    logic [DW-1:0] reg_rdata;
    logic          reg_rvalid;
    logic          busy;

    ebi_bus_controller dut (
        .clk          (clk),
        .reset        (reset),
        .ebi_cs       (ebi_cs),
        .ebi_wr       (ebi_wr),
        .ebi_rd       (ebi_rd),
        .ebi_addr     (ebi_addr),
        .ebi_data_in  (ebi_data_in),
        .ebi_data_out (ebi_data_out),
        .ebi_data_oe  (ebi_data_oe),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .reg_rvalid   (reg_rvalid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int we_count = 0;
    int re_count = 0;
    int we_cycle = 0;
    logic oe_prev = 1'b0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t           wr_q[$];
    logic [DW-1:0] rd_q[$];
    wr_t           exp_w;
    logic [DW-1:0] exp_r;

    // Backend model: answers a reg_re after rsp_delay cycles when enabled
    bit            respond_en = 1'b0;
    int            rsp_delay = 2;
    int            rsp_cnt = 0;
    logic [DW-1:0] resp_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) rsp_cnt <= 0;
        else if (reg_re && respond_en) rsp_cnt <= rsp_delay;
        else if (rsp_cnt > 0) rsp_cnt <= rsp_cnt - 1;
    end
    assign reg_rvalid = (rsp_cnt == 1);
    assign reg_rdata  = resp_data;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reg_we) begin
            we_count++;
            we_cycle = cyc;
            tests_run++;
            if (wr_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_reg_we: got addr=%h data=%h, required no write", reg_addr, reg_wdata);
            end else begin
                exp_w = wr_q.pop_front();
                if (reg_addr !== exp_w.addr || reg_wdata !== exp_w.data) begin
                    tests_failed++;
                    $display("FAIL write_contents: got addr=%h data=%h, required addr=%h data=%h",
                             reg_addr, reg_wdata, exp_w.addr, exp_w.data);
                end
            end
        end
        if (reg_re) re_count++;
        if (reg_we && reg_re) begin
            tests_run++;
            tests_failed++;
            $display("FAIL we_re_overlap: got both high, required never together");
        end
        if (ebi_data_oe && !oe_prev) begin
            tests_run++;
            if (rd_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_oe: got data=%h, required no read", ebi_data_out);
            end else begin
                exp_r = rd_q.pop_front();
                if (ebi_data_out !== exp_r) begin
                    tests_failed++;
                    $display("FAIL read_data: got %h, required %h", ebi_data_out, exp_r);
                end
            end
        end
        oe_prev = ebi_data_oe;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle: got busy=%b, required 0", name, busy);
        end
    endtask

    task automatic rd_start(input logic [AW-1:0] a);
        @(negedge clk);
        ebi_addr = a;
        ebi_cs   = 1'b1;
        ebi_rd   = 1'b1;
    endtask

    task automatic release_all();
        @(negedge clk);
        ebi_cs = 1'b0;
        ebi_wr = 1'b0;
        ebi_rd = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
        @(negedge clk);
        ebi_addr    = a;
        ebi_data_in = d;
        ebi_cs      = 1'b1;
        ebi_wr      = 1'b1;
        repeat (hold) @(posedge clk);
        release_all();
    endtask

    task automatic wait_re(input int n0, input string name);
        int n = 0;
        while (re_count == n0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (re_count == n0) begin
            tests_failed++;
            $display("FAIL %s_re_seen: got no reg_re, required one", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({ebi_data_out, ebi_data_oe, reg_addr, reg_wdata, reg_we, reg_re, busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got dout=%h oe=%b addr=%h wdata=%h we=%b re=%b busy=%b, required all 0",
                     ebi_data_out, ebi_data_oe, reg_addr, reg_wdata, reg_we, reg_re, busy);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int n = we_count;
        int start;
        wr_q.push_back('{21'd1, 16'h000F});
        @(negedge clk);
        ebi_addr    = 21'd1;
        ebi_data_in = 16'h000F;
        ebi_cs      = 1'b1;
        ebi_wr      = 1'b1;
        start       = cyc + 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        ebi_cs = 1'b0;
        ebi_wr = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_busy: got %b, required 1", busy);
        end
        wait_idle("write");
        repeat (3) @(negedge clk);
        tests_run++;
        if (we_count != n + 1) begin
            tests_failed++;
            $display("FAIL write_pulses: got %0d, required %0d", we_count - n, 1);
        end
        tests_run++;
        if (we_cycle != start + 3) begin
            tests_failed++;
            $display("FAIL write_latency: got cycle %0d, required %0d", we_cycle - start + 1, 4);
        end
    endtask

    task automatic test_read_resp();
        int n = re_count;
        respond_en = 1'b1;
        rsp_delay  = 2;
        resp_data  = 16'h1234;
        rd_q.push_back(16'h1234);
        rd_start(21'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (ebi_data_oe !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_oe_high: got %b, required 1", ebi_data_oe);
        end
        release_all();
        wait_idle("read");
        repeat (2) @(negedge clk);
        tests_run++;
        if (ebi_data_oe !== 1'b0 || ebi_data_out !== 16'h1234) begin
            tests_failed++;
            $display("FAIL read_after: got oe=%b dout=%h, required oe=0 dout=1234", ebi_data_oe, ebi_data_out);
        end
        tests_run++;
        if (re_count != n + 1 || rd_q.size() != 0) begin
            tests_failed++;
            $display("FAIL read_pulses: got re=%0d pending=%0d, required re=1 pending=0", re_count - n, rd_q.size());
        end
    endtask

    task automatic status_read(input logic [DW-1:0] expv, input string name);
        int n = re_count;
        rd_q.push_back(expv);
        rd_start(STATUS);
        repeat (8) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (ebi_data_oe !== 1'b1 || ebi_data_out !== expv) begin
            tests_failed++;
            $display("FAIL %s: got oe=%b dout=%h, required oe=1 dout=%h", name, ebi_data_oe, ebi_data_out, expv);
        end
        release_all();
        wait_idle(name);
        tests_run++;
        if (re_count != n) begin
            tests_failed++;
            $display("FAIL %s_no_re: got %0d pulses, required 0", name, re_count - n);
        end
    endtask

    task automatic test_timeout();
        int n = re_count;
        int nw;
        respond_en = 1'b0;
        rd_q.push_back(16'hDEAD);
        rd_start(21'd2);
        repeat (30) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (ebi_data_oe !== 1'b1 || ebi_data_out !== 16'hDEAD) begin
            tests_failed++;
            $display("FAIL timeout_data: got oe=%b dout=%h, required oe=1 dout=dead", ebi_data_oe, ebi_data_out);
        end
        release_all();
        wait_idle("timeout");
        tests_run++;
        if (re_count != n + 1) begin
            tests_failed++;
            $display("FAIL timeout_re: got %0d pulses, required 1", re_count - n);
        end
        status_read(16'h0001, "status_one");
        nw = we_count;
        do_write(STATUS, 16'hFFFF, 4);
        wait_idle("status_write");
        repeat (3) @(negedge clk);
        tests_run++;
        if (we_count != nw) begin
            tests_failed++;
            $display("FAIL status_write_no_we: got %0d pulses, required 0", we_count - nw);
        end
        status_read(16'h0000, "status_zero");
    endtask

    task automatic test_simultaneous();
        int nw = we_count;
        int nr = re_count;
        wr_q.push_back('{21'd5, 16'hA5A5});
        @(negedge clk);
        ebi_addr    = 21'd5;
        ebi_data_in = 16'hA5A5;
        ebi_cs      = 1'b1;
        ebi_wr      = 1'b1;
        ebi_rd      = 1'b1;
        repeat (20) @(posedge clk);
        release_all();
        wait_idle("simul");
        repeat (3) @(negedge clk);
        tests_run++;
        if (we_count != nw + 1 || re_count != nr) begin
            tests_failed++;
            $display("FAIL simul_pulses: got we=%0d re=%0d, required we=1 re=0", we_count - nw, re_count - nr);
        end
    endtask

    task automatic test_wr_during_read();
        int nw = we_count;
        int nr = re_count;
        respond_en  = 1'b1;
        rsp_delay   = 8;
        resp_data   = 16'h5678;
        ebi_data_in = 16'h1111;
        rd_q.push_back(16'h5678);
        rd_start(21'd7);
        wait_re(nr, "wr_during_read");
        repeat (2) @(negedge clk);
        ebi_wr = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (ebi_data_oe !== 1'b1 || ebi_data_out !== 16'h5678) begin
            tests_failed++;
            $display("FAIL wr_during_read_data: got oe=%b dout=%h, required oe=1 dout=5678", ebi_data_oe, ebi_data_out);
        end
        release_all();
        wait_idle("wr_during_read");
        repeat (3) @(negedge clk);
        tests_run++;
        if (we_count != nw || re_count != nr + 1) begin
            tests_failed++;
            $display("FAIL wr_during_read_pulses: got we=%0d re=%0d, required we=0 re=1", we_count - nw, re_count - nr);
        end
    endtask

    task automatic test_reset_mid_read();
        int nr = re_count;
        int nw;
        respond_en = 1'b0;
        rd_start(21'd3);
        wait_re(nr, "reset_mid");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({ebi_data_out, ebi_data_oe, reg_addr, reg_wdata, reg_we, reg_re, busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got dout=%h oe=%b addr=%h wdata=%h we=%b re=%b busy=%b, required all 0",
                     ebi_data_out, ebi_data_oe, reg_addr, reg_wdata, reg_we, reg_re, busy);
        end
        release_all();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        nw = we_count;
        wr_q.push_back('{21'd9, 16'h3C3C});
        do_write(21'd9, 16'h3C3C, 3);
        wait_idle("post_reset_write");
        repeat (3) @(negedge clk);
        tests_run++;
        if (we_count != nw + 1 || wr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL post_reset_write: got we=%0d pending=%0d, required we=1 pending=0", we_count - nw, wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_resp();
        test_timeout();
        test_simultaneous();
        test_wr_during_read();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
